// File: rtl/tcb_img_pkg.sv
// Shared constants and FSM encoding for the 11x11 image stream packer.
package tcb_img_pkg;
    localparam int PIX_W    = 8;
    localparam int N_PIX    = 121;
    localparam int FRAME_W  = PIX_W * N_PIX;
    localparam int LAST_IDX = N_PIX - 1;

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } state_e;
endpackage

// File: rtl/tcb_img_frame_slot.sv
// One frame buffer: FRAME_W register with a pixel-indexed write port and async clear.
module tcb_img_frame_slot #(
    parameter int PIX_W = 8,
    parameter int N_PIX = 121
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [6:0]             idx,
    input  logic [PIX_W-1:0]       din,
    output logic [PIX_W*N_PIX-1:0] q
);
    // Pixel 0 occupies the most significant PIX_W bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (we) begin
            for (int unsigned i = 0; i < N_PIX; i++) begin
                if (idx == 7'(i)) begin
                    q[PIX_W*(N_PIX-1-i) +: PIX_W] <= din;
                end
            end
        end
    end
endmodule

// File: rtl/tcb_img_stream_packer.sv
// Packs an 11x11 pixel stream into 968-bit frames through a ping-pong buffer,
// flagging short/long frames via pix_last.
module tcb_img_stream_packer #(
    parameter int  PIX_W   = 8,
    parameter int  N_PIX   = 121,
    localparam int FRAME_W = PIX_W * N_PIX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_last,
    output logic [FRAME_W-1:0] img_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               frame_err,
    output logic [7:0]         err_cnt
);
    import tcb_img_pkg::*;

    localparam logic [6:0] LAST_K = 7'(N_PIX - 1);

    state_e             state, state_next;
    logic [6:0]         k;
    logic               wr_sel, rd_sel;
    logic [1:0]         occ, occ_next;
    logic               accept, pop, at_last, filling, commit, bad, ready_next;
    logic               we0, we1;
    logic [FRAME_W-1:0] q0, q1;

    always_comb begin
        accept  = pix_valid && pix_ready;
        pop     = valid_out && ready_in;
        at_last = (k == LAST_K);
        filling = accept && (state == FILL);
        commit  = filling && at_last && pix_last;
        // Short frame: last flag early; long frame: no last flag at the final index.
        bad     = filling && (at_last != pix_last);
        we0     = filling && !wr_sel;
        we1     = filling && wr_sel;

        occ_next = occ;
        if (commit && !pop)      occ_next = occ + 2'd1;
        else if (!commit && pop) occ_next = occ - 2'd1;

        state_next = state;
        if (accept) begin
            if (state == FILL && at_last && !pix_last) state_next = DROP;
            else if (state == DROP && pix_last)        state_next = FILL;
        end

        ready_next = (state_next == DROP) ? 1'b1 : (occ_next != 2'd2);
        img_out    = rd_sel ? q1 : q0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            k         <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            occ       <= '0;
            pix_ready <= 1'b0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_next;
            occ       <= occ_next;
            pix_ready <= ready_next;
            valid_out <= (occ_next != 2'd0);
            frame_err <= bad;
            if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (commit) wr_sel <= ~wr_sel;
            if (pop)    rd_sel <= ~rd_sel;
            if (filling) k <= (at_last || pix_last) ? 7'd0 : k + 7'd1;
        end
    end

    tcb_img_frame_slot #(.PIX_W(PIX_W), .N_PIX(N_PIX)) u_slot0 (
        .clk(clk), .rst(rst), .we(we0), .idx(k), .din(pix_data), .q(q0)
    );

    tcb_img_frame_slot #(.PIX_W(PIX_W), .N_PIX(N_PIX)) u_slot1 (
        .clk(clk), .rst(rst), .we(we1), .idx(k), .din(pix_data), .q(q1)
    );
endmodule

// File: tb/tb_tcb_img_stream_packer.sv
// Directed self-checking bench for tcb_img_stream_packer.
module tb_tcb_img_stream_packer;
    localparam int PIX_W = 8;
    localparam int N_PIX = 121;
    localparam int FW    = PIX_W * N_PIX;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_last = 1'b0;
    logic          ready_in = 1'b0;
    logic [7:0]    pix_data = '0;
    logic          pix_ready, valid_out, frame_err;
    logic [FW-1:0] img_out;
    logic [7:0]    err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_seen = 0;
    int valid_seen = 0;

    always #5 clk = ~clk;

    tcb_img_stream_packer #(.PIX_W(PIX_W), .N_PIX(N_PIX)) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
        .img_out(img_out), .valid_out(valid_out), .ready_in(ready_in),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always @(negedge clk) begin
        if (frame_err) ferr_seen++;
        if (valid_out) valid_seen++;
    end

    // kind 0..255: constant fill; 256: value = index; 257: value = 255 - index
    function automatic logic [7:0] gen_pix(input int kind, input int k);
        if (kind == 256) return 8'(k);
        if (kind == 257) return 8'(255 - k);
        return 8'(kind);
    endfunction

    function automatic logic [FW-1:0] frame_of(input int kind);
        logic [FW-1:0] f = '0;
        for (int i = 0; i < N_PIX; i++) f[FW-1-8*i -: 8] = gen_pix(kind, i);
        return f;
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        int p;
        n_checks++;
        if (got !== exp) begin
            p = -1;
            for (int i = 0; i < N_PIX; i++)
                if (p < 0 && got[FW-1-8*i -: 8] !== exp[FW-1-8*i -: 8]) p = i;
            n_fail++;
            $display("FAIL %s: got=%h exp=%h (low 64 bits), first differing pixel %0d",
                     tag, got[63:0], exp[63:0], p);
        end
    endtask

    // Entered and left at posedge+1; returns the pixel whose accept raised frame_err.
    task automatic send_frame(input int kind, input int len, input int last_at, input bit pop_on_last,
                              output int err_at, output int stalls);
        err_at = -1;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            pix_valid = 1'b1;
            pix_data  = gen_pix(kind, i);
            pix_last  = (i == last_at);
            if (pop_on_last && i == len - 1) ready_in = 1'b1;
            while (!pix_ready && stalls < 400) begin
                @(posedge clk); #1;
                stalls++;
            end
            if (!pix_ready) begin
                check("pix_ready_wait", pix_ready, 1);
                break;
            end
            @(posedge clk); #1;
            if (pop_on_last && i == len - 1) ready_in = 1'b0;
            if (frame_err) err_at = i;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic pop_one();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea, st, f0, v0;
        logic [FW-1:0] tmp;

        // Reset state
        #12;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_img_out", img_out, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", pix_ready, 1);

        // Single frame, value = index
        ready_in = 1'b1;
        f0 = ferr_seen;
        send_frame(256, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("single_valid", valid_out, 1);
        check("single_img", img_out, frame_of(256));
        tmp = img_out;
        check("single_msb", tmp[FW-1 -: 8], 8'h00);
        check("single_lsb", tmp[7:0], 8'h78);
        check("single_err_at", ea, -1);
        @(posedge clk); #1;
        check("single_valid_drop", valid_out, 0);
        check("single_no_ferr", ferr_seen - f0, 0);

        // Short frame, then a good frame
        f0 = ferr_seen; v0 = valid_seen;
        send_frame(8'hAA, 51, 50, 1'b0, ea, st);
        check("short_err_at", ea, 50);
        check("short_frame_err", frame_err, 1);
        check("short_err_cnt", err_cnt, 1);
        check("short_no_valid", valid_out, 0);
        @(posedge clk); #1;
        check("short_err_pulse_end", frame_err, 0);
        send_frame(257, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("short_next_valid", valid_out, 1);
        check("short_next_img", img_out, frame_of(257));
        @(posedge clk); #1;
        check("short_ferr_count", ferr_seen - f0, 1);
        check("short_valid_count", valid_seen - v0, 1);

        // Long frame: 126 pixels, last on the final one
        f0 = ferr_seen; v0 = valid_seen;
        send_frame(8'h3C, 126, 125, 1'b0, ea, st);
        check("long_err_at", ea, 120);
        check("long_stalls", st, 0);
        check("long_err_cnt", err_cnt, 2);
        check("long_ferr_count", ferr_seen - f0, 1);
        check("long_valid_count", valid_seen - v0, 0);
        check("long_ready", pix_ready, 1);
        send_frame(256, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("long_next_valid", valid_out, 1);
        check("long_next_img", img_out, frame_of(256));
        @(posedge clk); #1;
        check("long_next_pop", valid_out, 0);

        // Backpressure: A, B fill both slots; C must wait
        ready_in = 1'b0;
        send_frame(8'h11, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("bp_a_valid", valid_out, 1);
        check("bp_a_img", img_out, frame_of(8'h11));
        send_frame(8'h22, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("bp_b_stalls", st, 0);
        check("bp_full_ready", pix_ready, 0);
        pix_valid = 1'b1;
        pix_data  = 8'h33;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_stall_ready", pix_ready, 0);
            check("bp_stall_img", img_out, frame_of(8'h11));
        end
        pix_valid = 1'b0;
        pop_one();
        check("bp_b_img", img_out, frame_of(8'h22));
        check("bp_ready_after_pop", pix_ready, 1);
        send_frame(8'h33, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("bp_b_held", img_out, frame_of(8'h22));
        check("bp_full_again", pix_ready, 0);
        pop_one();
        check("bp_c_img", img_out, frame_of(8'h33));
        pop_one();
        check("bp_empty", valid_out, 0);

        // Commit and pop in the same cycle
        send_frame(8'h44, N_PIX, N_PIX-1, 1'b0, ea, st);
        send_frame(256, N_PIX, N_PIX-1, 1'b1, ea, st);
        check("sim_valid", valid_out, 1);
        check("sim_img", img_out, frame_of(256));
        check("sim_ready", pix_ready, 1);
        send_frame(8'h66, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("sim_no_bubble", st, 0);
        check("sim_full", pix_ready, 0);
        check("sim_held", img_out, frame_of(256));
        pop_one();
        check("sim_f_img", img_out, frame_of(8'h66));
        pop_one();
        check("sim_empty", valid_out, 0);

        // Reset in the middle of a frame with one frame buffered
        send_frame(8'h77, N_PIX, N_PIX-1, 1'b0, ea, st);
        send_frame(8'h12, 61, -1, 1'b0, ea, st);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_ready", pix_ready, 0);
        check("mid_rst_img", img_out, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", pix_ready, 1);
        check("post_rst_valid", valid_out, 0);
        ready_in = 1'b1;
        send_frame(257, N_PIX, N_PIX-1, 1'b0, ea, st);
        check("post_rst_frame_valid", valid_out, 1);
        check("post_rst_img", img_out, frame_of(257));
        @(posedge clk); #1;
        check("post_rst_pop", valid_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tcb_img_stream_packer.md
# tcb_img_stream_packer

Upstream input stage for `top_tcb_121_16_10`. Accepts an 11×11, 8-bit pixel stream, one pixel per handshake, and assembles each frame into the 968-bit parallel word the network consumes on `img_source`. Uses a two-slot ping-pong buffer so the next frame can be filled while the network holds the current one. Detects framing errors via `pix_last`.

## Interface
Parameters:
- `PIX_W`, 8: bits per pixel.
- `N_PIX`, 121: pixels per frame.
- `FRAME_W`, `PIX_W*N_PIX` (968): output frame width; derived, not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `pix_valid` in 1: upstream pixel valid.
- `pix_ready` out 1: packer can accept a pixel.
- `pix_data` in `PIX_W`: pixel value.
- `pix_last` in 1: marks the final pixel of a frame.
- `img_out` out `FRAME_W`: assembled frame; drives `img_source`.
- `valid_out` out 1: frame available; drives `valid_top`.
- `ready_in` in 1: consumer accepts the frame; from `ready_top`.
- `frame_err` out 1: one-cycle pulse on a malformed frame.
- `err_cnt` out 8: saturating count of malformed frames.

## Operation
- State is held in these registers:
  - pixel index `k` (0..120);
  - `wr_sel` and `rd_sel` (1 bit each);
  - `occ` (0..2);
  - FSM state: FILL or DROP.
- A pixel is accepted when `pix_valid && pix_ready`.
- In FILL, an accepted pixel `k` is written to `slot[wr_sel][FRAME_W-1-PIX_W*k -: PIX_W]`. Pixel 0 is at the MSB byte; pixel 120 is at bits [7:0].
- Accept at `k<120` with `pix_last=0`: `k` increments.
- Accept at `k<120` with `pix_last=1` (short frame):
  - pulse `frame_err`;
  - increment `err_cnt`;
  - set `k` to 0;
  - the slot is not committed and its contents are don't-care until overwritten.
- Accept at `k==120` with `pix_last=1`: commit the frame. `occ` increments, `wr_sel` toggles, `k` resets to 0.
- Accept at `k==120` with `pix_last=0` (long frame):
  - pulse `frame_err`;
  - increment `err_cnt`;
  - discard the frame;
  - set `k` to 0;
  - go to DROP.
- DROP:
  - `pix_ready=1`;
  - accepted pixels are discarded and nothing is written;
  - accepting a pixel with `pix_last=1` returns the FSM to FILL;
  - no further `frame_err` pulse.
- Pop occurs on `valid_out && ready_in`: `rd_sel` toggles and `occ` decrements.
- Commit and pop in the same cycle: `occ` is unchanged and both pointers toggle.
- `valid_out` = (`occ`≠0).
- `img_out` = `slot[rd_sel]`. It is held stable while `valid_out=1` and `ready_in=0`.
- `pix_ready` is registered:
  - next value in FILL = (`occ_next`≠2);
  - next value in DROP = 1.
- There is no combinational path from `ready_in` or `pix_valid` to any output.
- `err_cnt` saturates at 255.

## Timing
- Reset values:
  - `pix_ready=0`, `valid_out=0`, `frame_err=0`, `err_cnt=0`;
  - `img_out` = all zeros (both slots cleared);
  - `occ=0`, `k=0`, pointers 0, FSM in FILL.
- `pix_ready` rises on the first rising edge after `rst` deasserts.
- Latency: when the last pixel is accepted at edge t, `valid_out` is 1 after edge t (when `occ` was 0). The frame is visible on `img_out` in the same cycle.
- Throughput: 1 pixel/cycle, i.e. 121 cycles per frame. Back-to-back frames run with no bubble while the consumer pops within 121 cycles.
- Full condition: when commit makes `occ=2`, `pix_ready` is 0 from the next cycle.
- A pop from `occ=2` raises `pix_ready` one cycle after the pop edge.
- `frame_err` is high for exactly the one cycle after the offending accept edge.
- Reset asserted mid-operation:
  - all outputs return to reset values immediately (asynchronous);
  - any partial or buffered frames are lost.

## Structure
- Shared package `tcb_img_pkg` holds:
  - `PIX_W`, `N_PIX`, `FRAME_W`;
  - the FSM state encoding (FILL=0, DROP=1);
  - `LAST_IDX=120`.
- Sub-module `tcb_img_frame_slot` is instantiated twice. It holds one `FRAME_W` register with a byte-indexed write port (`we`, `idx[6:0]`, `din[7:0]`) and async clear.
- The top level contains the FSM, the index counter, the pointers, `occ`, the error counter and the output mux.

## Test plan
- **Single frame:** reset, then 121 pixels with value = `k` (0x00..0x78) and `pix_last` on `k=120`, with `ready_in=1`.
  - `valid_out`=1 for one cycle after the last accept.
  - `img_out[967:960]`=0x00, `img_out[7:0]`=0x78.
  - `frame_err` never asserts.
- **Backpressure:** hold `ready_in=0` and stream 3 frames (A=0x11, B=0x22, C=0x33 fill).
  - `pix_ready` drops after B commits and C is not accepted.
  - Raise `ready_in`: outputs appear in order A, B, C with `img_out` stable while stalled.
- **Short frame:** `pix_last` at `k=50`.
  - `frame_err` pulses once, `err_cnt`=1, no `valid_out`.
  - The following good frame is delivered bit-exact.
- **Long frame:** no `pix_last` at `k=120`, then 5 more pixels with the last one flagged.
  - `frame_err` pulses once, after the accept of pixel 120.
  - Extra pixels are absorbed with `pix_ready=1` and no `valid_out`.
  - The next frame is correct.
- **Simultaneous commit and pop:** with `occ=1`, commit in the same cycle as `ready_in=1`.
  - `occ` stays 1, `pix_ready` stays 1, and the next frame follows with zero bubble.
- **Reset mid-frame:** assert `rst` low at `k=60`.
  - `valid_out`, `pix_ready` and `img_out` go to 0 without waiting for a clock edge.
  - After release, a fresh frame is delivered correctly.
